spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sclk_div.sv | 29 ++
 rtl/spi_master_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master controller and its helpers.
package spi_pkg;

   localparam int DEFAULT_FRAME_WIDTH = 16;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } spi_state_t;

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period timer for the SPI clock: ticks on the last clk cycle of each
// CLK_DIV-long sclk phase and restarts from zero whenever asked to.
module spi_sclk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = enable && (count == LAST);

   // Count clk cycles within the current sclk half-period, wrapping on the tick.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         count <= '0;
      end else if (enable) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: one FRAME_WIDTH-bit MSB-first full-duplex transfer per
// accepted start, with programmable ss setup, hold and inter-frame gap.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int FRAME_WIDTH = DEFAULT_FRAME_WIDTH,
   parameter int CLK_DIV     = 2,
   parameter int SS_SETUP    = 2,
   parameter int SS_HOLD     = 2,
   parameter int SS_GAP      = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [FRAME_WIDTH-1:0] tx_data,
   output logic                   busy,
   output logic                   done,
   output logic [FRAME_WIDTH-1:0] rx_data,
   output logic                   sclk,
   output logic                   ss,
   output logic                   mosi,
   input  logic                   miso
);

   localparam int CNT_W = $clog2(FRAME_WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_WIDTH - 1);
   localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
   localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);
   localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);

   spi_state_t state;
   spi_state_t state_next;

   logic [FRAME_WIDTH-1:0] tx_shift;
   logic [FRAME_WIDTH-1:0] rx_shift;
   logic [CNT_W-1:0]       bit_cnt;
   logic [15:0]            phase_cnt;
   logic                   half_tick;
   logic                   div_enable;
   logic                   div_restart;

   assign div_enable  = (state == HIGH) || (state == LOW);
   assign div_restart = (state == SETUP);
   assign mosi        = tx_shift[FRAME_WIDTH-1];

   spi_sclk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_div (
      .clk     (clk),
      .reset   (reset),
      .enable  (div_enable),
      .restart (div_restart),
      .tick    (half_tick)
   );

   // State register; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decision plus the pin levels implied by the current state.
   always_comb begin
      state_next = state;
      ss         = 1'b1;
      sclk       = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_next = SETUP;
         end
         SETUP: begin
            ss = 1'b0;
            if (phase_cnt == SETUP_LAST) state_next = HIGH;
         end
         HIGH: begin
            ss   = 1'b0;
            sclk = 1'b1;
            if (half_tick) state_next = LOW;
         end
         LOW: begin
            ss = 1'b0;
            if (half_tick) state_next = (bit_cnt == LAST_BIT) ? HOLD : HIGH;
         end
         HOLD: begin
            ss = 1'b0;
            if (phase_cnt == HOLD_LAST) state_next = GAP;
         end
         GAP: begin
            if (phase_cnt == GAP_LAST) state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: phase timing, shift registers, bit count and the completion pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_shift  <= '0;
         rx_shift  <= '0;
         bit_cnt   <= '0;
         phase_cnt <= '0;
         rx_data   <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;

         if (state_next != state) begin
            phase_cnt <= '0;
         end else if ((state == SETUP) || (state == HOLD) || (state == GAP)) begin
            phase_cnt <= phase_cnt + 16'd1;
         end

         if ((state == IDLE) && start) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            bit_cnt  <= '0;
         end

         if ((state_next == HIGH) && (state != HIGH)) begin
            rx_shift <= {rx_shift[FRAME_WIDTH-2:0], miso};
         end

         if ((state == HIGH) && (state_next == LOW)) begin
            tx_shift <= {tx_shift[FRAME_WIDTH-2:0], 1'b0};
         end

         if ((state == LOW) && (state_next == HIGH)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end

         if ((state == HOLD) && (state_next == GAP)) begin
            rx_data <= rx_shift;
            done    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: a behavioural slave and frame
// monitor observe the pins, and expected values come from the frame rules.
module tb_spi_master_ctrl;

   localparam int TB_FW    = 16;
   localparam int TB_DIV   = 2;
   localparam int TB_SETUP = 2;
   localparam int TB_HOLD  = 2;
   localparam int TB_GAP   = 4;

   localparam int EXP_LOW      = TB_SETUP + 2 * TB_DIV * TB_FW + TB_HOLD;
   localparam int EXP_GAP_HIGH = TB_GAP + 1;
   localparam int EXP_FAST_LOW = TB_SETUP + 2 * 1 * TB_FW + TB_HOLD;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [TB_FW-1:0]  tx_data = '0;
   logic              busy;
   logic              done;
   logic [TB_FW-1:0]  rx_data;
   logic              sclk;
   logic              ss;
   logic              mosi;
   logic              miso = 1'b0;

   logic              f_start = 1'b0;
   logic [TB_FW-1:0]  f_tx = '0;
   logic              f_busy;
   logic              f_done;
   logic [TB_FW-1:0]  f_rx;
   logic              f_sclk;
   logic              f_ss;
   logic              f_mosi;
   logic              f_miso;

   assign f_miso = 1'b0;

   int checks = 0;
   int errors = 0;

   spi_master_ctrl #(
      .FRAME_WIDTH (TB_FW),
      .CLK_DIV     (TB_DIV),
      .SS_SETUP    (TB_SETUP),
      .SS_HOLD     (TB_HOLD),
      .SS_GAP      (TB_GAP)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sclk    (sclk),
      .ss      (ss),
      .mosi    (mosi),
      .miso    (miso)
   );

   spi_master_ctrl #(
      .FRAME_WIDTH (TB_FW),
      .CLK_DIV     (1),
      .SS_SETUP    (TB_SETUP),
      .SS_HOLD     (TB_HOLD),
      .SS_GAP      (TB_GAP)
   ) dut_fast (
      .clk     (clk),
      .reset   (reset),
      .start   (f_start),
      .tx_data (f_tx),
      .busy    (f_busy),
      .done    (f_done),
      .rx_data (f_rx),
      .sclk    (f_sclk),
      .ss      (f_ss),
      .mosi    (f_mosi),
      .miso    (f_miso)
   );

   // Free-running system clock.
   always #5 clk = ~clk;

   // Slave model and pin monitor for the default-parameter instance.
   logic [TB_FW-1:0] slave_word = '0;
   logic [TB_FW-1:0] sl_tx = '0;
   logic [TB_FW-1:0] sl_rx = '0;
   logic prev_ss = 1'b1;
   logic prev_sclk = 1'b0;
   logic prev_done = 1'b0;
   bit   seen_frame = 1'b0;
   int   ss_low_len = 0;
   int   ss_high_len = 0;
   int   done_run = 0;
   int   busy_low_run = 0;
   int   sclk_run = 0;
   int   done_events = 0;
   int   ss_low_q[$];
   int   ss_high_q[$];
   int   done_w_q[$];
   int   busy_low_q[$];
   int   sclk_hi_q[$];
   logic [TB_FW-1:0] slave_q[$];

   always @(negedge clk) begin
      if (done && !prev_done) done_events++;
      if (done) begin
         done_run++;
      end else if (done_run > 0) begin
         done_w_q.push_back(done_run);
         done_run = 0;
      end
      if (!busy) begin
         busy_low_run++;
      end else if (busy_low_run > 0) begin
         busy_low_q.push_back(busy_low_run);
         busy_low_run = 0;
      end
      if (sclk) begin
         sclk_run++;
      end else if (sclk_run > 0) begin
         sclk_hi_q.push_back(sclk_run);
         sclk_run = 0;
      end
      if (!ss) begin
         if (prev_ss) begin
            if (seen_frame) ss_high_q.push_back(ss_high_len);
            ss_low_len = 0;
            sl_rx = '0;
            sl_tx = slave_word;
            miso = sl_tx[TB_FW-1];
         end
         ss_low_len++;
         if (sclk && !prev_sclk) sl_rx = {sl_rx[TB_FW-2:0], mosi};
         if (!sclk && prev_sclk) begin
            sl_tx = {sl_tx[TB_FW-2:0], 1'b0};
            miso = sl_tx[TB_FW-1];
         end
      end else begin
         if (!prev_ss) begin
            ss_low_q.push_back(ss_low_len);
            slave_q.push_back(sl_rx);
            ss_high_len = 0;
            seen_frame = 1'b1;
         end
         ss_high_len++;
      end
      prev_ss = ss;
      prev_sclk = sclk;
      prev_done = done;
   end

   // Pin monitor for the CLK_DIV=1 instance: sclk period, mosi level, ss width.
   int   cycle = 0;
   logic f_prev_ss = 1'b1;
   logic f_prev_sclk = 1'b0;
   int   f_low = 0;
   int   f_low_last = 0;
   int   f_rises = 0;
   int   f_ones = 0;
   int   f_bad_period = 0;
   int   f_last_rise = 0;

   always @(negedge clk) begin
      cycle++;
      if (!f_ss) begin
         if (f_prev_ss) begin
            f_low = 0;
            f_rises = 0;
            f_ones = 0;
            f_bad_period = 0;
         end
         f_low++;
         if (f_sclk && !f_prev_sclk) begin
            f_rises++;
            if (f_mosi) f_ones++;
            if ((f_rises > 1) && ((cycle - f_last_rise) != 2)) f_bad_period++;
            f_last_rise = cycle;
         end
      end else if (!f_prev_ss) begin
         f_low_last = f_low;
      end
      f_prev_ss = f_ss;
      f_prev_sclk = f_sclk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while (busy && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
   endtask

   // Launch one frame, optionally disturb tx_data or start, and wait for it to finish.
   task automatic applyStimulus(input logic [TB_FW-1:0] tx, input logic [TB_FW-1:0] sw,
                                input bit change_tx, input int poke_at,
                                output logic [TB_FW-1:0] rx_seen, output bit got_done);
      waitIdle();
      slave_word = sw;
      tx_data = tx;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (change_tx) tx_data = ~tx;
      checkOutput("busy_after_accept", 32'(busy), 32'd1);
      checkOutput("ss_in_setup", 32'(ss), 32'd0);
      got_done = 1'b0;
      rx_seen = '0;
      for (int i = 1; i < 400; i++) begin
         start = (poke_at == i);
         if (done) begin
            got_done = 1'b1;
            rx_seen = rx_data;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      waitIdle();
      repeat (3) @(negedge clk);
   endtask

   // Frame-level expectations for the most recent frame on the default instance.
   task automatic checkLastFrame(input string tag, input logic [TB_FW-1:0] tx, input logic [TB_FW-1:0] sw,
                                 input logic [TB_FW-1:0] rx_seen, input bit got_done, input int ev0);
      checkOutput({tag, "_done_seen"}, 32'(got_done), 32'd1);
      checkOutput({tag, "_rx"}, 32'(rx_seen), 32'(sw));
      checkOutput({tag, "_slave_rx"}, 32'(slave_q[slave_q.size()-1]), 32'(tx));
      checkOutput({tag, "_ss_low"}, 32'(ss_low_q[ss_low_q.size()-1]), 32'(EXP_LOW));
      checkOutput({tag, "_done_width"}, 32'(done_w_q[done_w_q.size()-1]), 32'd1);
      checkOutput({tag, "_done_count"}, 32'(done_events - ev0), 32'd1);
   endtask

   initial begin
      logic [TB_FW-1:0] tx;
      logic [TB_FW-1:0] sw;
      logic [TB_FW-1:0] rx_seen;
      bit               got_done;
      int               ev0;
      int               lo0;
      int               hi0;
      int               bl0;
      int               dw0;
      int               sh0;
      int               bad;
      int               n;
      int               rises;
      logic             ps;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset_ss", 32'(ss), 32'd1);
      checkOutput("reset_sclk", 32'(sclk), 32'd0);
      checkOutput("reset_mosi", 32'(mosi), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_rx", 32'(rx_data), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Directed frame D5F9 / 3C5A with sclk half-period check.
      ev0 = done_events;
      sh0 = sclk_hi_q.size();
      applyStimulus(16'hD5F9, 16'h3C5A, 1'b0, 0, rx_seen, got_done);
      checkLastFrame("d5f9", 16'hD5F9, 16'h3C5A, rx_seen, got_done, ev0);
      bad = 0;
      for (int k = sh0; k < sclk_hi_q.size(); k++) if (sclk_hi_q[k] != TB_DIV) bad++;
      checkOutput("d5f9_sclk_pulses", 32'(sclk_hi_q.size() - sh0), 32'(TB_FW));
      checkOutput("d5f9_sclk_width_bad", 32'(bad), 32'd0);

      // Randomized frames, some with tx_data changed after acceptance or a stray start.
      for (int i = 0; i < 6; i++) begin
         tx = TB_FW'($urandom);
         sw = TB_FW'($urandom);
         ev0 = done_events;
         applyStimulus(tx, sw, (i % 2) == 1, (i >= 2) ? int'($urandom_range(60, 2)) : 0, rx_seen, got_done);
         checkLastFrame($sformatf("rand%0d", i), tx, sw, rx_seen, got_done, ev0);
      end

      // Back-to-back frames with start held high.
      waitIdle();
      tx = TB_FW'($urandom);
      sw = TB_FW'($urandom);
      ev0 = done_events;
      lo0 = ss_low_q.size();
      hi0 = ss_high_q.size();
      bl0 = busy_low_q.size();
      dw0 = done_w_q.size();
      slave_word = sw;
      tx_data = tx;
      start = 1'b1;
      n = 0;
      while ((done_events < ev0 + 3) && (n < 600)) begin
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      checkOutput("b2b_frames", 32'(done_events - ev0), 32'd3);
      waitIdle();
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("b2b_ss_low%0d", k), 32'(ss_low_q[lo0 + k]), 32'(EXP_LOW));
         checkOutput($sformatf("b2b_slave_rx%0d", k), 32'(slave_q[lo0 + k]), 32'(tx));
         checkOutput($sformatf("b2b_done_width%0d", k), 32'(done_w_q[dw0 + k]), 32'd1);
      end
      for (int k = 1; k < 3; k++) begin
         checkOutput($sformatf("b2b_ss_gap%0d", k), 32'(ss_high_q[hi0 + k]), 32'(EXP_GAP_HIGH));
         checkOutput($sformatf("b2b_busy_low%0d", k), 32'(busy_low_q[bl0 + k]), 32'd1);
      end
      checkOutput("b2b_rx", 32'(rx_data), 32'(sw));

      // Reset on the 8th sclk rise, then a normal frame 0001.
      waitIdle();
      slave_word = TB_FW'($urandom);
      tx_data = TB_FW'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rises = 0;
      ps = sclk;
      n = 0;
      while ((rises < 8) && (n < 200)) begin
         @(negedge clk);
         n++;
         if (sclk && !ps) rises++;
         ps = sclk;
      end
      checkOutput("abort_rise_reached", 32'(rises), 32'd8);
      ev0 = done_events;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("abort_ss", 32'(ss), 32'd1);
      checkOutput("abort_sclk", 32'(sclk), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_rx", 32'(rx_data), 32'd0);
      reset = 1'b0;
      repeat (80) @(negedge clk);
      checkOutput("abort_no_done", 32'(done_events - ev0), 32'd0);
      sw = TB_FW'($urandom);
      ev0 = done_events;
      applyStimulus(16'h0001, sw, 1'b0, 0, rx_seen, got_done);
      checkLastFrame("after_abort", 16'h0001, sw, rx_seen, got_done, ev0);

      // CLK_DIV=1 instance: all-ones frame against a slave holding miso low.
      f_tx = 16'hFFFF;
      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      f_tx = 16'h1234;
      n = 0;
      while (!f_done && (n < 200)) begin
         @(negedge clk);
         n++;
      end
      checkOutput("fast_done_seen", 32'(f_done), 32'd1);
      checkOutput("fast_rx", 32'(f_rx), 32'd0);
      repeat (10) @(negedge clk);
      checkOutput("fast_rises", 32'(f_rises), 32'(TB_FW));
      checkOutput("fast_mosi_ones", 32'(f_ones), 32'(TB_FW));
      checkOutput("fast_period_bad", 32'(f_bad_period), 32'd0);
      checkOutput("fast_ss_low", 32'(f_low_last), 32'(EXP_FAST_LOW));
      checkOutput("fast_busy_end", 32'(f_busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      errors++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
